// File: rtl/uart_resp_rx.sv
// uart_resp_rx: 8N1 serial receiver for replies from the radio module, with a
// line matcher that pulses on an exact "OK\r\n" or "ERROR\r\n" line.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   rx_i           asynchronous serial line, idle high
//   data_o         last received byte, held until the next valid byte
//   data_valid_o   one-cycle strobe, data_o is new
//   frame_err_o    one-cycle strobe, stop bit sampled low
//   ok_pulse_o     one-cycle strobe, line "OK\r\n" completed
//   error_pulse_o  one-cycle strobe, line "ERROR\r\n" completed
//   busy_o         high while a frame is in progress (start through stop bit)
module uart_resp_rx #(
  parameter int unsigned BAUD = 434  // clock cycles per bit, >= 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       ok_pulse_o,
  output logic       error_pulse_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(BAUD);
  localparam logic [CntW-1:0] CntFull = CntW'(BAUD - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BAUD / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  logic            rx_meta_q, rx_s_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            data_valid_q, frame_err_q;
  logic [2:0]      ok_idx_q, er_idx_q;
  logic            ok_dead_q, er_dead_q;
  logic            ok_pulse_q, error_pulse_q;
  logic [7:0]      ok_exp, er_exp;

  // Two-flop synchroniser; nothing downstream looks at rx_i directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM. Every state change reloads the bit-time counter to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          // Mid-bit check of the start bit rejects short glitches.
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};  // LSB arrives first
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitHigh: begin
          // A held-low line (break) reports one frame error, not a stream of them.
          if (rx_s_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Expected next character of each reply; only meaningful below the terminal index.
  always_comb begin
    ok_exp = 8'h00;
    case (ok_idx_q)
      3'd0:    ok_exp = 8'h4F;  // 'O'
      3'd1:    ok_exp = 8'h4B;  // 'K'
      3'd2:    ok_exp = 8'h0D;  // CR
      default: ok_exp = 8'h00;
    endcase
  end

  always_comb begin
    er_exp = 8'h00;
    case (er_idx_q)
      3'd0:    er_exp = 8'h45;  // 'E'
      3'd1:    er_exp = 8'h52;  // 'R'
      3'd2:    er_exp = 8'h52;  // 'R'
      3'd3:    er_exp = 8'h4F;  // 'O'
      3'd4:    er_exp = 8'h52;  // 'R'
      3'd5:    er_exp = 8'h0D;  // CR
      default: er_exp = 8'h00;
    endcase
  end

  // Line matcher: any mismatch kills the line until the next LF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ok_idx_q      <= '0;
      er_idx_q      <= '0;
      ok_dead_q     <= 1'b0;
      er_dead_q     <= 1'b0;
      ok_pulse_q    <= 1'b0;
      error_pulse_q <= 1'b0;
    end else begin
      ok_pulse_q    <= 1'b0;
      error_pulse_q <= 1'b0;
      if (frame_err_q) begin
        ok_dead_q <= 1'b1;
        er_dead_q <= 1'b1;
      end else if (data_valid_q) begin
        if (data_q == 8'h0A) begin
          ok_pulse_q    <= (ok_idx_q == 3'd3) && !ok_dead_q;
          error_pulse_q <= (er_idx_q == 3'd6) && !er_dead_q;
          ok_idx_q      <= '0;
          er_idx_q      <= '0;
          ok_dead_q     <= 1'b0;
          er_dead_q     <= 1'b0;
        end else begin
          if (ok_idx_q < 3'd3 && data_q == ok_exp) ok_idx_q <= ok_idx_q + 1'b1;
          else                                     ok_dead_q <= 1'b1;
          if (er_idx_q < 3'd6 && data_q == er_exp) er_idx_q <= er_idx_q + 1'b1;
          else                                     er_dead_q <= 1'b1;
        end
      end
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = data_valid_q;
  assign frame_err_o   = frame_err_q;
  assign ok_pulse_o    = ok_pulse_q;
  assign error_pulse_o = error_pulse_q;
  assign busy_o        = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_resp_rx.sv
// tb_uart_resp_rx: drives serial frames into uart_resp_rx; expected strobes are
// queued by a line-level reference model and checked by an independent monitor.
module tb_uart_resp_rx;

  localparam int unsigned BAUD = 16;
  localparam int EvData = 0, EvFerr = 1, EvOk = 2, EvErr = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, ok_pulse, error_pulse, busy;

  uart_resp_rx #(.BAUD(BAUD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .data_o       (data),
    .data_valid_o (data_valid),
    .frame_err_o  (frame_err),
    .ok_pulse_o   (ok_pulse),
    .error_pulse_o(error_pulse),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  ev_t        sb[$];
  logic [7:0] line_q[$];
  bit         line_bad = 1'b0;
  logic [7:0] last_data = 8'h00;
  int unsigned fall_cyc = 0;
  int unsigned dv_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit line_is(input string s);
    if (line_q.size() != s.len()) return 1'b0;
    foreach (line_q[i]) if (line_q[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endfunction

  // Reference model: a byte is accepted as a line character; LF ends the line and
  // only an intact, exact "OK\r" or "ERROR\r" line produces a pulse.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      push_ev(EvFerr, last_data);
      line_bad = 1'b1;
      return;
    end
    push_ev(EvData, b);
    last_data = b;
    if (b == 8'h0A) begin
      if (!line_bad && line_is("OK\r"))    push_ev(EvOk, 8'h00);
      if (!line_bad && line_is("ERROR\r")) push_ev(EvErr, 8'h00);
      line_q.delete();
      line_bad = 1'b0;
    end else begin
      line_q.push_back(b);
    end
  endfunction

  // Monitor: every strobe must match the head of the scoreboard.
  task automatic mon(input int kind, input logic [7:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d data %0h expected none", kind, val);
    end else begin
      e = sb.pop_front();
      chk("strobe_kind", kind, e.kind);
      chk("strobe_data", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cyc = cyc;
        mon(EvData, data);
      end
      if (frame_err) mon(EvFerr, data);
      if (ok_pulse) begin
        mon(EvOk, 8'h00);
        chk("ok_after_lf", cyc - dv_cyc, 1);
      end
      if (error_pulse) begin
        mon(EvErr, 8'h00);
        chk("err_after_lf", cyc - dv_cyc, 1);
      end
      if (ok_pulse && error_pulse) chk("pulse_excl", 1, 0);
    end
  end

  // Called at a negedge; leaves rx high after the stop bit unless the stop bit is 0.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    chk("busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BAUD) @(negedge clk);
    if (stop_ok) rx = 1'b1;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      if (gaps) repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_data"}, data, last_data);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_strobes"}, {data_valid, frame_err, ok_pulse, error_pulse}, 4'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string      alpha;
    string      base;
    logic [7:0] bytes_q[$];
    int         r;

    alpha = "OKERokx \r";
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Single frame with latency check.
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    chk("latency_ok", (dv_cyc - fall_cyc >= 154) && (dv_cyc - fall_cyc <= 156), 1);
    chk("data_0x41", data, 8'h41);

    send_str("OK\r\n", 1'b0);
    send_str("ERROR\r\n", 1'b0);
    send_str("OK\r\n", 1'b0);
    send_str("OOK\r\n", 1'b0);
    send_str("OK\n", 1'b0);
    send_str("ok\r\n", 1'b0);
    send_str("OK \r\n", 1'b0);
    send_str("xOK\r\n", 1'b0);

    // Bad stop bit followed by a 30-bit-time break.
    send_str("OK", 1'b0);
    send_byte(8'h55, 1'b0);
    repeat (30 * BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
    chk("data_held_ferr", data, 8'h4B);
    send_str("\r\n", 1'b0);
    send_str("OK\r\n", 1'b0);

    // 3-clk glitch must be rejected silently.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
    check_idle_outputs("glitch");

    // Reset in the middle of the data bits of 0x4F.
    send_str("OK", 1'b0);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = r[0] ^ 1'b0;
      rx = (8'h4F >> i) & 1'b1;
      repeat (BAUD) @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    line_q.delete();
    line_bad  = 1'b0;
    last_data = 8'h00;
    repeat (BAUD * 12) @(negedge clk);
    check_idle_outputs("mid_reset");
    send_str("OK\r\n", 1'b0);

    // Randomised lines: exact replies, single-char mutations and junk.
    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 3);
      bytes_q.delete();
      base = (r == 1 || ($urandom_range(0, 1) == 1 && r == 2)) ? "ERROR\r" : "OK\r";
      if (r == 3) begin
        for (int k = 0; k < $urandom_range(1, 5); k++)
          bytes_q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
      end else begin
        for (int k = 0; k < base.len(); k++) bytes_q.push_back(base[k]);
        if (r == 2) bytes_q[$urandom_range(0, base.len() - 1)] =
            alpha[$urandom_range(0, alpha.len() - 1)];
      end
      bytes_q.push_back(8'h0A);
      foreach (bytes_q[k]) begin
        send_byte(bytes_q[k], 1'b1);
        repeat ($urandom_range(0, 2 * BAUD)) @(negedge clk);
      end
    end

    repeat (4 * BAUD) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
